// File: rtl/fpu_result_checker.sv
// FPU result checker: buffers FPU results in a FIFO and pairs them in order
// with golden vectors, counting compares/mismatches and capturing the first miss.
module fpu_result_checker #(
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter bit NAN_EQUIV   = 1'b1,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             db,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [63:0]      res_fp,
    input  logic [4:0]       res_ieee,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [63:0]      exp_fp,
    input  logic [4:0]       exp_ieee,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_valid,
    output logic [CNT_W-1:0] err_index,
    output logic [68:0]      err_got,
    output logic [68:0]      err_exp,
    output logic             halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t state, state_nxt;

    logic [63:0]   fp_mem   [DEPTH];
    logic [4:0]    ieee_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          res_ready_q, res_ready_nxt;
    logic          full, empty, push, pop;
    logic [63:0]   head_fp, mask, res_m, exp_m;
    logic [4:0]    head_ieee;
    logic          data_eq, match, mismatch;

    function automatic logic is_nan(input logic [63:0] v, input logic dbl);
        if (dbl)
            return (&v[62:52]) && (|v[51:0]);
        return (&v[30:23]) && (|v[22:0]);
    endfunction

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign res_ready = res_ready_q;
    assign exp_ready = ~empty && (state == RUN);
    assign halted    = (state == HALT);
    assign push      = res_valid && res_ready_q;
    assign pop       = exp_valid && exp_ready;

    assign head_fp   = fp_mem[rd_ptr];
    assign head_ieee = ieee_mem[rd_ptr];
    assign mask      = db ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    assign res_m     = head_fp & mask;
    assign exp_m     = exp_fp & mask;

    // NaN payload and sign are don't-care when both sides are NaN
    assign data_eq   = (res_m == exp_m) ||
                       (NAN_EQUIV && is_nan(res_m, db) && is_nan(exp_m, db));
    assign match     = data_eq && (head_ieee == exp_ieee);
    assign mismatch  = pop && !match;

    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = IDLE;
        else begin
            case (state)
                IDLE:    if (enable) state_nxt = RUN;
                RUN:     if (mismatch && STOP_ON_ERR) state_nxt = HALT;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        count_nxt = count;
        if (clear)
            count_nxt = '0;
        else begin
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end
        // A slot freed by a pop only becomes writable on the following cycle
        res_ready_nxt = (state_nxt != HALT) && (count_nxt != FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            fp_mem[wr_ptr]   <= res_fp;
            ieee_mem[wr_ptr] <= res_ieee;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            res_ready_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            res_ready_q <= res_ready_nxt;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_cnt   <= '0;
            err_cnt   <= '0;
            err_valid <= 1'b0;
            err_index <= '0;
            err_got   <= '0;
            err_exp   <= '0;
        end else if (clear) begin
            vec_cnt   <= '0;
            err_cnt   <= '0;
            err_valid <= 1'b0;
            err_index <= '0;
            err_got   <= '0;
            err_exp   <= '0;
        end else if (pop) begin
            if (vec_cnt != '1)
                vec_cnt <= vec_cnt + CNT_W'(1);
            if (!match) begin
                if (err_cnt != '1)
                    err_cnt <= err_cnt + CNT_W'(1);
                if (!err_valid) begin
                    err_valid <= 1'b1;
                    err_index <= vec_cnt;
                    err_got   <= {head_ieee, head_fp};
                    err_exp   <= {exp_ieee, exp_fp};
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_checker.sv
// Directed bench: DUT a (NaN-equivalent, free-running) and DUT b (bit-exact,
// stop on error) share stimulus; expected values come from hand tables.
module tb_fpu_result_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic        db = 1'b0;
    logic        res_valid = 1'b0;
    logic [63:0] res_fp = '0;
    logic [4:0]  res_ieee = '0;
    logic        exp_valid = 1'b0;
    logic [63:0] exp_fp = '0;
    logic [4:0]  exp_ieee = '0;

    logic        res_ready_a, exp_ready_a, err_valid_a, halted_a;
    logic [15:0] vec_cnt_a, err_cnt_a, err_index_a;
    logic [68:0] err_got_a, err_exp_a;
    logic        res_ready_b, exp_ready_b, err_valid_b, halted_b;
    logic [15:0] vec_cnt_b, err_cnt_b, err_index_b;
    logic [68:0] err_got_b, err_exp_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_result_checker #(
        .DEPTH(8), .CNT_W(16), .NAN_EQUIV(1'b1), .STOP_ON_ERR(1'b0)
    ) u_a (
        .clk(clk), .rst(rst), .clear(clear), .enable(enable), .db(db),
        .res_valid(res_valid), .res_ready(res_ready_a),
        .res_fp(res_fp), .res_ieee(res_ieee),
        .exp_valid(exp_valid), .exp_ready(exp_ready_a),
        .exp_fp(exp_fp), .exp_ieee(exp_ieee),
        .vec_cnt(vec_cnt_a), .err_cnt(err_cnt_a), .err_valid(err_valid_a),
        .err_index(err_index_a), .err_got(err_got_a), .err_exp(err_exp_a),
        .halted(halted_a)
    );

    fpu_result_checker #(
        .DEPTH(8), .CNT_W(16), .NAN_EQUIV(1'b0), .STOP_ON_ERR(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .clear(clear), .enable(enable), .db(db),
        .res_valid(res_valid), .res_ready(res_ready_b),
        .res_fp(res_fp), .res_ieee(res_ieee),
        .exp_valid(exp_valid), .exp_ready(exp_ready_b),
        .exp_fp(exp_fp), .exp_ieee(exp_ieee),
        .vec_cnt(vec_cnt_b), .err_cnt(err_cnt_b), .err_valid(err_valid_b),
        .err_index(err_index_b), .err_got(err_got_b), .err_exp(err_exp_b),
        .halted(halted_b)
    );

    typedef struct {
        logic        db;
        logic [63:0] rfp;
        logic [4:0]  rie;
        logic [63:0] efp;
        logic [4:0]  eie;
        logic        ma;
        logic        mb;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    int m_vec_a, m_err_a, m_vec_b, m_err_b, acc;
    bit b_halt;

    initial begin
        tbl[0] = '{1'b0, 64'h3F80_0000, 5'd0, 64'h3F80_0000, 5'd0, 1'b1, 1'b1};
        tbl[1] = tbl[0];
        tbl[2] = tbl[0];
        tbl[3] = tbl[0];
        tbl[4] = '{1'b0, 64'hDEAD_BEEF_3F80_0000, 5'd0,
                   64'h0000_0000_3F80_0000, 5'd0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 64'h7FF8_0000_0000_0001, 5'd0,
                   64'hFFF8_0000_0000_0000, 5'd0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 64'hDEAD_BEEF_3F80_0000, 5'd0,
                   64'h0000_0000_3F80_0000, 5'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 64'h7FC0_0000, 5'd0, 64'hFFC0_0001, 5'd0, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 64'h3F80_0000, 5'd1, 64'h3F80_0000, 5'd0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 64'h7F80_0000, 5'd0, 64'h7FC0_0000, 5'd0, 1'b0, 1'b0};

        // reset state
        @(negedge clk);
        chk("rst_res_ready", res_ready_a, 0);
        chk("rst_exp_ready", exp_ready_a, 0);
        chk("rst_vec_cnt", vec_cnt_a, 0);
        chk("rst_err_valid", err_valid_a, 0);
        chk("rst_halted", halted_b, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_res_ready", res_ready_a, 1);
        enable = 1'b1;
        @(negedge clk);

        // table: one push then one compare per vector
        m_vec_a = 0; m_err_a = 0; m_vec_b = 0; m_err_b = 0; b_halt = 0;
        for (int i = 0; i < 10; i++) begin
            res_valid = 1'b1;
            res_fp    = tbl[i].rfp;
            res_ieee  = tbl[i].rie;
            @(negedge clk);
            res_valid = 1'b0;
            exp_valid = 1'b1;
            exp_fp    = tbl[i].efp;
            exp_ieee  = tbl[i].eie;
            db        = tbl[i].db;
            chk($sformatf("v%0d_exp_ready", i), exp_ready_a, 1);
            @(negedge clk);
            exp_valid = 1'b0;
            m_vec_a++;
            if (!tbl[i].ma) m_err_a++;
            if (!b_halt) begin
                m_vec_b++;
                if (!tbl[i].mb) begin
                    m_err_b++;
                    b_halt = 1;
                end
            end
            chk($sformatf("v%0d_vec_a", i), vec_cnt_a, m_vec_a);
            chk($sformatf("v%0d_err_a", i), err_cnt_a, m_err_a);
            chk($sformatf("v%0d_vec_b", i), vec_cnt_b, m_vec_b);
            chk($sformatf("v%0d_err_b", i), err_cnt_b, m_err_b);
            chk($sformatf("v%0d_halt_b", i), halted_b, b_halt);
        end
        chk("tbl_err_index_a", err_index_a, 6);
        chk("tbl_err_got_a", err_got_a, {5'd0, 64'hDEAD_BEEF_3F80_0000});
        chk("tbl_err_exp_a", err_exp_a, {5'd0, 64'h0000_0000_3F80_0000});
        chk("tbl_err_valid_a", err_valid_a, 1);
        chk("tbl_err_index_b", err_index_b, 5);
        chk("tbl_err_got_b", err_got_b, {5'd0, 64'h7FF8_0000_0000_0001});
        chk("tbl_res_ready_b", res_ready_b, 0);

        // stop on error: vector 2 carries a flag difference
        enable = 1'b0;
        clear  = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        db    = 1'b0;
        for (int k = 0; k < 6; k++) begin
            res_valid = 1'b1;
            res_fp    = 64'h3F80_0000 + 64'(k);
            res_ieee  = (k == 2) ? 5'd1 : 5'd0;
            @(negedge clk);
        end
        res_valid = 1'b0;
        enable    = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            exp_valid = 1'b1;
            exp_fp    = 64'h3F80_0000 + 64'(k);
            exp_ieee  = 5'd0;
            @(negedge clk);
        end
        exp_valid = 1'b0;
        chk("stop_halted_b", halted_b, 1);
        chk("stop_err_index_b", err_index_b, 2);
        chk("stop_vec_cnt_b", vec_cnt_b, 3);
        chk("stop_res_ready_b", res_ready_b, 0);
        chk("stop_err_got_b", err_got_b, {5'd1, 64'h3F80_0002});
        chk("stop_vec_cnt_a", vec_cnt_a, 6);
        chk("stop_err_cnt_a", err_cnt_a, 1);
        chk("stop_halted_a", halted_a, 0);

        // clear with FIFO half full and a captured error
        for (int k = 0; k < 4; k++) begin
            res_valid = 1'b1;
            res_fp    = 64'h55 + 64'(k);
            res_ieee  = 5'd0;
            @(negedge clk);
        end
        res_valid = 1'b0;
        enable    = 1'b0;
        clear     = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_vec_cnt", vec_cnt_a, 0);
        chk("clr_err_cnt", err_cnt_a, 0);
        chk("clr_err_valid", err_valid_a, 0);
        chk("clr_err_index", err_index_a, 0);
        chk("clr_halted_b", halted_b, 0);
        chk("clr_res_ready_b", res_ready_b, 1);
        enable = 1'b1;
        @(negedge clk);
        chk("clr_fifo_empty", exp_ready_a, 0);

        // prefill DEPTH+2 in IDLE, then drain in order
        enable = 1'b0;
        clear  = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        acc   = 0;
        for (int k = 0; k < 10; k++) begin
            res_valid = 1'b1;
            res_fp    = 64'h100 + 64'(k);
            res_ieee  = 5'd0;
            if (res_ready_a) acc++;
            @(negedge clk);
        end
        res_valid = 1'b0;
        chk("pre_accepted", acc, 8);
        chk("pre_full_ready", res_ready_a, 0);
        enable = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                chk("pre_pushpop_full", res_ready_a, 0);
                res_valid = 1'b1;
                res_fp    = 64'hBAD;
            end else begin
                res_valid = 1'b0;
            end
            exp_valid = 1'b1;
            exp_fp    = 64'h100 + 64'(k);
            exp_ieee  = 5'd0;
            @(negedge clk);
        end
        exp_valid = 1'b0;
        res_valid = 1'b0;
        chk("drain_vec_cnt", vec_cnt_a, 8);
        chk("drain_err_cnt", err_cnt_a, 0);
        chk("drain_empty", exp_ready_a, 0);

        // async reset mid-RUN discards FIFO
        for (int k = 0; k < 3; k++) begin
            res_valid = 1'b1;
            res_fp    = 64'h77;
            @(negedge clk);
        end
        res_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_vec_cnt", vec_cnt_a, 0);
        chk("arst_res_ready", res_ready_a, 0);
        chk("arst_exp_ready", exp_ready_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arst_fifo_empty", exp_ready_a, 0);
        chk("arst_res_ready_up", res_ready_a, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
